weight_buffer_writer: RTL and testbench

WEIGHT_BUFFER_WRITER -- requirements
Module: weight_buffer_writer

---
 rtl/weight_buffer_writer_pkg.sv | 35 +++
 rtl/wbw_addr_gen.sv | 81 ++++++++
 rtl/weight_buffer_writer.sv | 173 +++++++++++++++++
 tb/tb_weight_buffer_writer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_writer_pkg.sv
// -----------------------------------------------------------------------------
// weight_buffer_writer_pkg
//
// Shared definitions for the weight buffer writer:
//   - wbw_state_e      : load FSM states (idle, load, done)
//   - Shape*           : bit offsets and width of the {w,h,c} fields in the
//                        shape bus
//   - ChanWrapShift    : channels per stream word are 64, so the number of
//                        words per (x,y) column entry is c >> 6
//   - ColLenW/TotalW   : arithmetic widths for column length / base and the
//                        total beat count
// -----------------------------------------------------------------------------
package weight_buffer_writer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } wbw_state_e;

    localparam int unsigned ShapeFieldW   = 16;
    localparam int unsigned ShapeCLsb     = 0;
    localparam int unsigned ShapeHLsb     = 16;
    localparam int unsigned ShapeWLsb     = 32;
    localparam int unsigned ChanWrapShift = 6;

    localparam int unsigned ColLenW = 24;
    localparam int unsigned TotalW  = 32;

    // Number of stream words that carry the channels of one (x,y) position.
    function automatic logic [ShapeFieldW-1:0] calc_n_wrap(input logic [ShapeFieldW-1:0] c);
        return c >> ChanWrapShift;
    endfunction

endpackage

// File: rtl/wbw_addr_gen.sv
// -----------------------------------------------------------------------------
// wbw_addr_gen
//
// Incremental bank/address generator for the weight buffer writer. Walks the
// stream order (x outer, y/channel-word inner) without any dividers:
//   j    : word index within the current x column (0 .. col_len-1)
//   rx   : bank of the current column (x mod N_BUF_X)
//   base : first address of the current column in its bank (qx * col_len)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   clear       in   restart from beat 0 (accepted start)
//   advance     in   current beat accepted; step to the next beat
//   col_len     in   words per x column
//   bank_onehot out  one-hot bank of the current beat
//   addr        out  low B_BUF_ADDR bits of base + j
//   in_range    out  base + j fits into a bank (<= 2^B_BUF_ADDR - 1)
// -----------------------------------------------------------------------------
module wbw_addr_gen
    import weight_buffer_writer_pkg::*;
#(
    parameter int unsigned N_BUF_X    = 5,
    parameter int unsigned B_BUF_ADDR = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [ColLenW-1:0]    col_len,
    output logic [N_BUF_X-1:0]    bank_onehot,
    output logic [B_BUF_ADDR-1:0] addr,
    output logic                  in_range
);

    localparam int unsigned RxW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;

    logic [ColLenW-1:0] j_q;
    logic [ColLenW-1:0] base_q;
    logic [RxW-1:0]     rx_q;

    logic               j_last;
    logic               rx_last;
    // One extra bit so base + j never wraps before the range check.
    logic [ColLenW:0]   addr_full;

    assign j_last    = (j_q == col_len - ColLenW'(1));
    assign rx_last   = (rx_q == RxW'(N_BUF_X - 1));
    assign addr_full = {1'b0, base_q} + {1'b0, j_q};
    assign addr      = addr_full[B_BUF_ADDR-1:0];
    assign in_range  = ((addr_full >> B_BUF_ADDR) == '0);

    always_comb begin
        bank_onehot = '0;
        for (int unsigned i = 0; i < N_BUF_X; i++) begin
            bank_onehot[i] = (rx_q == RxW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            j_q    <= '0;
            rx_q   <= '0;
            base_q <= '0;
        end else if (advance) begin
            if (j_last) begin
                j_q <= '0;
                if (rx_last) begin
                    // All banks received one column: next column row.
                    rx_q   <= '0;
                    base_q <= base_q + col_len;
                end else begin
                    rx_q <= rx_q + RxW'(1);
                end
            end else begin
                j_q <= j_q + ColLenW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_buffer_writer.sv
// -----------------------------------------------------------------------------
// weight_buffer_writer
//
// Streams weight words from an AXI-Stream style input into N_BUF_X
// x-interleaved weight banks. A start in idle latches the shape, derives the
// column length and total beat count, and consumes exactly that many beats.
// Each accepted beat produces one registered bank write one cycle later.
//
// Optional feature: define WBW_TLAST_CHECK_EN to add s_axis_tlast; a tlast on
// any beat other than the last, or a missing tlast on the last beat, sets err.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   wei_shape      in   {w,h,c} shape, sampled on accepted start
//   start          in   load request (only honoured in idle)
//   s_axis_tdata   in   weight word
//   s_axis_tvalid  in   word valid
//   s_axis_tlast   in   last word marker (WBW_TLAST_CHECK_EN only)
//   s_axis_tready  out  high while loading
//   wren           out  one-hot bank write enable
//   wraddr         out  bank write address (shared)
//   wrdata         out  bank write data (shared)
//   busy           out  high while loading
//   done           out  one-cycle completion pulse
//   err            out  sticky error, cleared on accepted start
// -----------------------------------------------------------------------------
module weight_buffer_writer
    import weight_buffer_writer_pkg::*;
#(
    parameter int unsigned N_BUF_X    = 5,
    parameter int unsigned B_BUF_ADDR = 9,
    parameter int unsigned B_SHAPE    = 48,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [B_SHAPE-1:0]    wei_shape,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
`ifdef WBW_TLAST_CHECK_EN
    input  logic                  s_axis_tlast,
`endif
    output logic                  s_axis_tready,
    output logic [N_BUF_X-1:0]    wren,
    output logic [B_BUF_ADDR-1:0] wraddr,
    output logic [DATA_WIDTH-1:0] wrdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    wbw_state_e state_q, state_d;

    logic [ColLenW-1:0]    col_len_q;
    logic [TotalW-1:0]     total_q;
    logic [TotalW-1:0]     count_q;
    logic                  err_q;
    logic [N_BUF_X-1:0]    wren_q;
    logic [B_BUF_ADDR-1:0] wraddr_q;
    logic [DATA_WIDTH-1:0] wrdata_q;

    logic [ShapeFieldW-1:0] shape_c;
    logic [ShapeFieldW-1:0] shape_h;
    logic [ShapeFieldW-1:0] shape_w;
    logic [ShapeFieldW-1:0] n_wrap;
    logic [ColLenW-1:0]     col_len_calc;
    logic [TotalW-1:0]      total_calc;

    logic                  start_acc;
    logic                  accept;
    logic                  last_beat;
    logic                  tlast_err;

    logic [N_BUF_X-1:0]    gen_bank;
    logic [B_BUF_ADDR-1:0] gen_addr;
    logic                  gen_in_range;

    // Shape decode and size arithmetic, only consumed on an accepted start.
    assign shape_c      = wei_shape[ShapeCLsb +: ShapeFieldW];
    assign shape_h      = wei_shape[ShapeHLsb +: ShapeFieldW];
    assign shape_w      = wei_shape[ShapeWLsb +: ShapeFieldW];
    assign n_wrap       = calc_n_wrap(shape_c);
    assign col_len_calc = ColLenW'(shape_h) * ColLenW'(n_wrap);
    assign total_calc   = TotalW'(shape_w) * TotalW'(col_len_calc);

    assign start_acc = (state_q == StIdle) && start;
    assign accept    = s_axis_tvalid && s_axis_tready;
    assign last_beat = (count_q == total_q - TotalW'(1));

`ifdef WBW_TLAST_CHECK_EN
    assign tlast_err = accept && (s_axis_tlast != last_beat);
`else
    assign tlast_err = 1'b0;
`endif

    wbw_addr_gen #(
        .N_BUF_X    (N_BUF_X),
        .B_BUF_ADDR (B_BUF_ADDR)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_acc),
        .advance     (accept),
        .col_len     (col_len_q),
        .bank_onehot (gen_bank),
        .addr        (gen_addr),
        .in_range    (gen_in_range)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (total_calc == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (accept && last_beat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            col_len_q <= '0;
            total_q   <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            wren_q    <= '0;
            wraddr_q  <= '0;
            wrdata_q  <= '0;
        end else begin
            state_q <= state_d;

            if (start_acc) begin
                col_len_q <= col_len_calc;
                total_q   <= total_calc;
                count_q   <= '0;
                err_q     <= 1'b0;
            end else if (accept) begin
                count_q <= count_q + TotalW'(1);
                if (!gen_in_range || tlast_err) begin
                    err_q <= 1'b1;
                end
            end

            // Out-of-range beats are consumed but never written.
            wren_q <= (accept && gen_in_range) ? gen_bank : '0;
            if (accept) begin
                wraddr_q <= gen_addr;
                wrdata_q <= s_axis_tdata;
            end
        end
    end

    // state_q is a register, so these decodes are glitch-free registered flags.
    assign s_axis_tready = (state_q == StLoad);
    assign busy          = (state_q == StLoad);
    assign done          = (state_q == StDone);
    assign err           = err_q;
    assign wren          = wren_q;
    assign wraddr        = wraddr_q;
    assign wrdata        = wrdata_q;

endmodule

// File: tb/tb_weight_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_weight_buffer_writer
//
// Directed self-checking bench for weight_buffer_writer. Expected bank/address
// values come from a division-based reference of the stream order.
// -----------------------------------------------------------------------------
module tb_weight_buffer_writer;

    localparam int N_BUF_X    = 5;
    localparam int B_BUF_ADDR = 9;
    localparam int B_SHAPE    = 48;
    localparam int DATA_WIDTH = 64;
    localparam int AddrMax    = (1 << B_BUF_ADDR) - 1;
`ifdef WBW_TLAST_CHECK_EN
    localparam bit TlastEn = 1'b1;
`else
    localparam bit TlastEn = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [B_SHAPE-1:0]    wei_shape;
    logic                  start;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
`ifdef WBW_TLAST_CHECK_EN
    logic                  s_axis_tlast;
`endif
    logic                  s_axis_tready;
    logic [N_BUF_X-1:0]    wren;
    logic [B_BUF_ADDR-1:0] wraddr;
    logic [DATA_WIDTH-1:0] wrdata;
    logic                  busy;
    logic                  done;
    logic                  err;

    int checks = 0;
    int errors = 0;

    logic [N_BUF_X-1:0]    log_wren[$];
    logic [B_BUF_ADDR-1:0] log_addr[$];

    always #5 clk = ~clk;

    weight_buffer_writer #(
        .N_BUF_X    (N_BUF_X),
        .B_BUF_ADDR (B_BUF_ADDR),
        .B_SHAPE    (B_SHAPE),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wei_shape     (wei_shape),
        .start         (start),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
`ifdef WBW_TLAST_CHECK_EN
        .s_axis_tlast  (s_axis_tlast),
`endif
        .s_axis_tready (s_axis_tready),
        .wren          (wren),
        .wraddr        (wraddr),
        .wrdata        (wrdata),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_wren"},   64'(wren),          64'd0);
        check({tag, "_wraddr"}, 64'(wraddr),        64'd0);
        check({tag, "_wrdata"}, wrdata,             64'd0);
        check({tag, "_busy"},   64'(busy),          64'd0);
        check({tag, "_done"},   64'(done),          64'd0);
        check({tag, "_err"},    64'(err),           64'd0);
    endtask

    task automatic do_start(input int c, input int h, input int w);
        wei_shape = {16'(w), 16'(h), 16'(c)};
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Drives n_stop beats of a load of 'total' beats and checks every cycle's
    // write port against the reference stream order.
    task automatic stream(input int col_len, input int total, input int n_stop, input bit gap,
                          input int tlast_beat);
        int k = 0;
        int cyc = 0;
        bit acc;
        bit m_err = 1'b0;
        int x;
        int j;
        int a;
        logic [N_BUF_X-1:0] exp_wren;
        log_wren.delete();
        log_addr.delete();
        while (k < n_stop && cyc < 2 * n_stop + 10) begin
            s_axis_tvalid = gap ? ((cyc % 2) == 0) : 1'b1;
            s_axis_tdata  = {32'hC0DE_0000, 32'(k)};
`ifdef WBW_TLAST_CHECK_EN
            s_axis_tlast  = (k == tlast_beat);
`endif
            acc = s_axis_tvalid && s_axis_tready;
            tick();
            cyc++;
            if (acc) begin
                x        = k / col_len;
                j        = k % col_len;
                a        = (x / N_BUF_X) * col_len + j;
                exp_wren = N_BUF_X'(1 << (x % N_BUF_X));
                if (a > AddrMax) begin
                    exp_wren = '0;
                    m_err    = 1'b1;
                end
                if (TlastEn && ((k == tlast_beat) != (k == total - 1))) m_err = 1'b1;
                check("wren", 64'(wren), 64'(exp_wren));
                if (exp_wren != '0) begin
                    check("wraddr", 64'(wraddr), 64'(a));
                    check("wrdata", wrdata, {32'hC0DE_0000, 32'(k)});
                end
                check("err", 64'(err), 64'(m_err));
                check("done", 64'(done), 64'(k == total - 1));
                log_wren.push_back(wren);
                log_addr.push_back(wraddr);
                k++;
            end else begin
                check("gap_wren", 64'(wren), 64'd0);
            end
        end
        s_axis_tvalid = 1'b0;
        if (k < n_stop) check("stream_timeout", 64'(k), 64'(n_stop));
    endtask

    initial begin
        int n_wr;
        rst           = 1'b1;
        start         = 1'b0;
        wei_shape     = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
`ifdef WBW_TLAST_CHECK_EN
        s_axis_tlast  = 1'b0;
`endif
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // c=64,h=3,w=7: col_len 3, 21 beats, continuous valid.
        do_start(64, 3, 7);
        check("start_busy", 64'(busy), 64'd1);
        check("start_tready", 64'(s_axis_tready), 64'd1);
        check("start_err", 64'(err), 64'd0);
        // A start while loading must not disturb the load.
        wei_shape = {16'd1, 16'd1, 16'd32};
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("start_ignored_busy", 64'(busy), 64'd1);
        stream(3, 21, 21, 1'b0, 20);
        check("cont_nwrites", 64'(log_wren.size()), 64'd21);
        check("cont_b15_wren", 64'(log_wren[15]), 64'b00001);
        check("cont_b15_addr", 64'(log_addr[15]), 64'd3);
        check("cont_b20_wren", 64'(log_wren[20]), 64'b00010);
        check("cont_b20_addr", 64'(log_addr[20]), 64'd5);
        tick();
        check("cont_done_end", 64'(done), 64'd0);
        check("cont_busy_end", 64'(busy), 64'd0);
        check("cont_wren_end", 64'(wren), 64'd0);

        // Same shape, valid every other cycle.
        do_start(64, 3, 7);
        stream(3, 21, 21, 1'b1, 20);
        check("gap_b15_wren", 64'(log_wren[15]), 64'b00001);
        check("gap_b15_addr", 64'(log_addr[15]), 64'd3);
        check("gap_b20_wren", 64'(log_wren[20]), 64'b00010);
        check("gap_b20_addr", 64'(log_addr[20]), 64'd5);
        tick();
        check("gap_done_end", 64'(done), 64'd0);

        // c=32 gives n_wrap=0: straight to done, no stream.
        do_start(32, 3, 7);
        check("zero_done", 64'(done), 64'd1);
        check("zero_tready", 64'(s_axis_tready), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("zero_idle_tready", 64'(s_axis_tready), 64'd0);
            check("zero_idle_wren", 64'(wren), 64'd0);
            check("zero_idle_done", 64'(done), 64'd0);
        end
        s_axis_tvalid = 1'b0;

        // Reset after beat 10 abandons the load.
        do_start(64, 3, 7);
        stream(3, 21, 11, 1'b0, 20);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_nodone", 64'(done), 64'd0);
        do_start(128, 2, 1);
        stream(4, 4, 4, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            check("rst_reload_wren", 64'(log_wren[i]), 64'b00001);
            check("rst_reload_addr", 64'(log_addr[i]), 64'(i));
        end
        tick();
        check("rst_reload_done_end", 64'(done), 64'd0);

`ifdef WBW_TLAST_CHECK_EN
        // Misplaced tlast on beat 5 sets err but the load still completes.
        do_start(64, 3, 7);
        stream(3, 21, 21, 1'b0, 5);
        check("tlast_err_sticky", 64'(err), 64'd1);
        tick();
        do_start(64, 3, 7);
        check("tlast_err_cleared", 64'(err), 64'd0);
        stream(3, 21, 21, 1'b0, 20);
        check("tlast_ok_err", 64'(err), 64'd0);
        tick();
`endif

        // c=64,h=200,w=30: base runs past the bank depth.
        do_start(64, 200, 30);
        stream(200, 6000, 6000, 1'b0, 5999);
        n_wr = 0;
        foreach (log_wren[i]) if (log_wren[i] != '0) n_wr++;
        // Columns 0..9 fully fit (2000), columns 10..14 fit j=0..111 (560).
        check("oor_nwrites", 64'(n_wr), 64'd2560);
        check("oor_err", 64'(err), 64'd1);
        tick();
        check("oor_done_end", 64'(done), 64'd0);
        check("oor_err_hold", 64'(err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
